// File: rtl/imem_arbiter.sv
`default_nettype none
// =============================================================================
// imem_arbiter : arbitrates fetch and debug reads onto a single registered-read
//                instruction memory port, with debug starvation relief and lock.
// Revision     : 1.0
// =============================================================================
module imem_arbiter #(
   parameter int AW       = 30,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_stall,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,

   input  logic          d_req,
   input  logic [AW-1:0] d_addr,
   input  logic          d_lock,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,

   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic {
      OWN_F = 1'b0,
      OWN_D = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_F    = 2'd1,
      OWNER_D    = 2'd2
   } owner_e;

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   state_e        state_q,     state_d;
   owner_e        owner_q,     owner_d;
   logic [7:0]    wait_cnt_q,  wait_cnt_d;
   logic [AW-1:0] last_addr_q, last_addr_d;
   logic          starve;

   assign starve = (wait_cnt_q >= WAIT_LIMIT);

   // Grants are combinational so the winning address reaches memory this cycle.
   always_comb begin
      f_gnt   = 1'b0;
      d_gnt   = 1'b0;
      state_d = state_q;
      if (!rst) begin
         case (state_q)
            OWN_F: begin
               if (f_req && !starve) begin
                  f_gnt = 1'b1;
               end else if (d_req) begin
                  d_gnt = 1'b1;
               end
               if (d_gnt && d_lock) begin
                  state_d = OWN_D;
               end
            end
            OWN_D: begin
               d_gnt = d_req;
               if (!d_lock || !d_req) begin
                  state_d = OWN_F;
               end
            end
            default: state_d = OWN_F;
         endcase
      end
   end

   always_comb begin
      mem_addr = last_addr_q;
      if (rst) begin
         mem_addr = '0;
      end else if (f_gnt) begin
         mem_addr = f_addr;
      end else if (d_gnt) begin
         mem_addr = d_addr;
      end
   end

   always_comb begin
      last_addr_d = last_addr_q;
      owner_d     = OWNER_NONE;
      if (f_gnt) begin
         owner_d     = OWNER_F;
         last_addr_d = mem_addr;
      end else if (d_gnt) begin
         owner_d     = OWNER_D;
         last_addr_d = mem_addr;
      end
   end

   // Counts only consecutive unserved debug cycles; saturates instead of wrapping.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (d_gnt || !d_req) begin
         wait_cnt_d = 8'd0;
      end else if (wait_cnt_q != 8'hFF) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= OWN_F;
         owner_q     <= OWNER_NONE;
         wait_cnt_q  <= 8'd0;
         last_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         wait_cnt_q  <= wait_cnt_d;
         last_addr_q <= last_addr_d;
      end
   end

   assign f_stall  = f_req & ~f_gnt;
   assign f_rvalid = (owner_q == OWNER_F);
   assign d_rvalid = (owner_q == OWNER_D);
   assign f_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_imem_arbiter : reference-model scoreboard bench for imem_arbiter.
// Revision        : 1.0
// =============================================================================
module tb_imem_arbiter;

   localparam int AW       = 30;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 8;

   logic          clk;
   logic          rst;
   logic          f_req, d_req, d_lock;
   logic [AW-1:0] f_addr, d_addr;
   logic          f_gnt, f_stall, f_rvalid, d_gnt, d_rvalid;
   logic [DW-1:0] f_rdata, d_rdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   imem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk      (clk),
      .rst      (rst),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_gnt    (f_gnt),
      .f_stall  (f_stall),
      .f_rvalid (f_rvalid),
      .f_rdata  (f_rdata),
      .d_req    (d_req),
      .d_addr   (d_addr),
      .d_lock   (d_lock),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return {2'b11, a} ^ 32'h0F0F_1234;
   endfunction

   // Registered-read memory model.
   always @(posedge clk) mem_rdata <= word(mem_addr);

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
   } sb_t;

   sb_t sb_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model state
   int            m_state, m_owner, m_wait, run_len;
   logic [AW-1:0] m_last;

   logic          o_fg, o_dg, o_fs, o_fv, o_dv;
   logic [AW-1:0] o_ma;
   logic [DW-1:0] o_frd, o_drd;

   task automatic step(input logic r, input logic fr, input logic [AW-1:0] fa,
                       input logic dr, input logic [AW-1:0] da, input logic dl);
      logic          eg_f, eg_d;
      logic [AW-1:0] e_addr;
      sb_t           ent;
      rst = r; f_req = fr; f_addr = fa; d_req = dr; d_addr = da; d_lock = dl;
      @(negedge clk);
      o_fg = f_gnt; o_dg = d_gnt; o_fs = f_stall; o_fv = f_rvalid; o_dv = d_rvalid;
      o_ma = mem_addr; o_frd = f_rdata; o_drd = d_rdata;

      eg_f = 1'b0; eg_d = 1'b0; e_addr = m_last;
      if (r) begin
         e_addr = '0;
      end else begin
         if (m_state == 0) begin
            if (fr && m_wait < MAX_WAIT) eg_f = 1'b1;
            else if (dr)                 eg_d = 1'b1;
         end else begin
            eg_d = dr;
         end
         if (eg_f)      e_addr = fa;
         else if (eg_d) e_addr = da;
      end

      check("f_gnt",    o_fg, eg_f);
      check("d_gnt",    o_dg, eg_d);
      check("f_stall",  o_fs, fr & ~eg_f);
      check("mem_addr", o_ma, e_addr);
      check("f_rvalid", o_fv, m_owner == 1);
      check("d_rvalid", o_dv, m_owner == 2);

      if (o_fv || o_dv) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            ent = sb_q.pop_front();
            check("rv_port", o_dv, ent.port);
            check("rdata",   o_fv ? o_frd : o_drd, ent.data);
         end
      end
      if (eg_f || eg_d) begin
         ent.port = eg_d;
         ent.data = word(e_addr);
         sb_q.push_back(ent);
      end

      if (!r && o_dg) check("dbg_wait_bound", run_len <= MAX_WAIT, 1);
      if (!r && dr && !o_dg) run_len++;
      else                   run_len = 0;

      if (r) begin
         m_state = 0; m_owner = 0; m_wait = 0; m_last = '0;
      end else begin
         m_owner = eg_f ? 1 : (eg_d ? 2 : 0);
         if (eg_f || eg_d) m_last = e_addr;
         if (eg_d || !dr)      m_wait = 0;
         else if (m_wait < 255) m_wait++;
         if (m_state == 0) begin
            if (eg_d && dl) m_state = 1;
         end else if (!dl || !dr) begin
            m_state = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   logic          r_fr, r_dr, r_dl, r_rst;
   logic [AW-1:0] r_fa, r_da;

   initial begin
      rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_lock = 1'b0; f_addr = '0; d_addr = '0;
      m_state = 0; m_owner = 0; m_wait = 0; m_last = '0; run_len = 0;
      @(posedge clk);
      #1;

      // Reset state
      do_reset();
      check("rst_fgnt", o_fg, 0);
      check("rst_maddr", o_ma, 0);
      check("rst_fvalid", o_fv, 0);

      // Streaming fetch, addresses 0..3
      do_reset();
      for (int c = 0; c < 5; c++) begin
         step(1'b0, c < 4, AW'(c), 1'b0, '0, 1'b0);
         check("t1_fgnt",   o_fg, c < 4);
         check("t1_fvalid", o_fv, c >= 1);
         if (c >= 1) check("t1_fdata", o_frd, word(AW'(c - 1)));
      end

      // Debug starvation relief
      do_reset();
      for (int c = 0; c < 10; c++) begin
         step(1'b0, 1'b1, AW'(100 + c), 1'b1, AW'(200), 1'b0);
         check("t2_dgnt",   o_dg, c == 8);
         check("t2_fstall", o_fs, c == 8);
         if (c == 8) check("t2_wait_clear", dut.wait_cnt_q, 0);
      end

      // Locked debug burst
      do_reset();
      for (int c = 0; c < 15; c++) begin
         step(1'b0, 1'b1, AW'(300 + c), c <= 13, AW'(400 + c), c <= 12);
         if (c >= 8 && c <= 13) begin
            check("t3_dgnt", o_dg, 1);
            check("t3_fgnt", o_fg, 0);
         end
         if (c == 14) check("t3_fetch_back", o_fg, 1);
      end

      // Address hold across idle cycles
      do_reset();
      step(1'b0, 1'b1, AW'(5), 1'b0, '0, 1'b0);
      check("t4_fgnt", o_fg, 1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
         check("t4_hold",   o_ma, 5);
         check("t4_fvalid", o_fv, k == 0);
      end

      // Reset during a locked debug burst
      do_reset();
      step(1'b0, 1'b0, '0, 1'b1, AW'(7), 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, AW'(9), 1'b1);
      check("t5_dgnt_burst", o_dg, 1);
      step(1'b1, 1'b0, '0, 1'b1, AW'(11), 1'b1);
      check("t5_dgnt_rst", o_dg, 0);
      check("t5_maddr_rst", o_ma, 0);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      check("t5_dvalid", o_dv, 0);
      check("t5_maddr", o_ma, 0);
      step(1'b0, 1'b1, AW'(3), 1'b1, AW'(4), 1'b1);
      check("t5_own_f", o_fg, 1);

      // Random traffic
      r_dr = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         r_rst = ($urandom_range(0, 999) == 0);
         r_fr  = ($urandom_range(0, 9) < 8);
         if (r_dr && !o_dg) r_dr = ($urandom_range(0, 9) < 9);
         else               r_dr = ($urandom_range(0, 9) < 5);
         r_dl  = $urandom_range(0, 1) == 1;
         r_fa  = AW'($urandom);
         r_da  = AW'($urandom);
         step(r_rst, r_fr, r_fa, r_dr, r_da, r_dl);
         check("never_both", o_fg & o_dg, 0);
      end

      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      check("sb_drain", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
